// File: rtl/gshare_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gshare_predictor: gshare direction predictor with tagged BTB, speculative |
// | global history and single-cycle recovery.  Rev 1.0                        |
// +--------------------------------------------------------------------------+
module gshare_predictor #(
  parameter int FETCH_WIDTH = 4,
  parameter int GHR_BITS    = 8,
  parameter int BHT_ENTRIES = 256,
  parameter int CTR_BITS    = 2,
  parameter int BTB_ENTRIES = 32,
  parameter int TAG_BITS    = 8,
  localparam int LANE_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [31:0]                   rd_pc,
  output logic [FETCH_WIDTH-1:0]        pred_taken,
  output logic [FETCH_WIDTH-1:0][31:0]  pred_target,
  output logic [FETCH_WIDTH-1:0]        pred_is_branch,
  output logic                          pred_any_taken,
  output logic [LANE_W-1:0]             pred_lane,
  output logic [GHR_BITS-1:0]           pred_ghr,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_pc,
  input  logic                          wr_taken,
  input  logic [31:0]                   wr_target,
  input  logic [GHR_BITS-1:0]           wr_ghr,
  input  logic                          wr_mispredict
);

  localparam int                c_BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam logic [CTR_BITS-1:0] c_CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] c_CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0]    bht_q        [BHT_ENTRIES];
  logic [CTR_BITS-1:0]    bht_d        [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_BITS-1:0]    btb_tag_q    [BTB_ENTRIES];
  logic [TAG_BITS-1:0]    btb_tag_d    [BTB_ENTRIES];
  logic [31:0]            btb_target_q [BTB_ENTRIES];
  logic [31:0]            btb_target_d [BTB_ENTRIES];
  logic [GHR_BITS-1:0]    ghr_q, ghr_d;

  logic [FETCH_WIDTH-1:0]       w_hit;
  logic [FETCH_WIDTH-1:0]       w_raw_taken;
  logic [FETCH_WIDTH-1:0]       w_taken;
  logic [FETCH_WIDTH-1:0]       w_in_group;
  logic [FETCH_WIDTH-1:0][31:0] w_target;
  logic                         w_found;
  logic [LANE_W-1:0]            w_lane;
  logic [GHR_BITS-1:0]          w_ghr_shift;

  // Per-lane lookup; every lane hashes with the same speculative history.
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    logic [31:0]             lane_pc;
    logic [GHR_BITS-1:0]     bht_idx;
    logic [c_BTB_IDX_W-1:0]  btb_idx;
    logic [TAG_BITS-1:0]     tag;
    logic                    w_unused_lane;

    assign lane_pc        = rd_pc + 32'(4 * i);
    assign bht_idx        = lane_pc[GHR_BITS+1:2] ^ ghr_q;
    assign btb_idx        = lane_pc[2 +: c_BTB_IDX_W];
    assign tag            = lane_pc[c_BTB_IDX_W+2 +: TAG_BITS];
    assign w_hit[i]       = btb_valid_q[btb_idx] && (btb_tag_q[btb_idx] == tag);
    assign w_raw_taken[i] = w_hit[i] && bht_q[bht_idx][CTR_BITS-1];
    assign w_target[i]    = w_hit[i] ? btb_target_q[btb_idx] : 32'h0;
    assign w_unused_lane  = ^lane_pc;
  end

  // Keep lanes up to and including the first taken one; those lanes also
  // define which branches contribute history bits.
  always_comb begin
    w_found    = 1'b0;
    w_taken    = '0;
    w_in_group = '0;
    w_lane     = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!w_found) begin
        w_in_group[i] = 1'b1;
        w_taken[i]    = w_raw_taken[i];
        if (w_raw_taken[i]) begin
          w_found = 1'b1;
          w_lane  = LANE_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_ghr_shift = ghr_q;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (w_hit[i] && w_in_group[i]) begin
        w_ghr_shift = {w_ghr_shift[GHR_BITS-2:0], w_taken[i]};
      end
    end
  end

  always_comb begin
    ghr_d = ghr_q;
    if (wr_en && wr_mispredict) begin
      ghr_d = {wr_ghr[GHR_BITS-2:0], wr_taken};
    end else if (rd_en) begin
      ghr_d = w_ghr_shift;
    end
  end

  logic [GHR_BITS-1:0]    w_wr_bht_idx;
  logic [c_BTB_IDX_W-1:0] w_wr_btb_idx;
  logic                   w_unused_wr;

  assign w_wr_bht_idx = wr_pc[GHR_BITS+1:2] ^ wr_ghr;
  assign w_wr_btb_idx = wr_pc[2 +: c_BTB_IDX_W];
  assign w_unused_wr  = ^wr_pc;

  always_comb begin
    bht_d        = bht_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (wr_en) begin
      if (wr_taken && (bht_q[w_wr_bht_idx] != c_CTR_MAX)) begin
        bht_d[w_wr_bht_idx] = bht_q[w_wr_bht_idx] + 1'b1;
      end else if (!wr_taken && (bht_q[w_wr_bht_idx] != '0)) begin
        bht_d[w_wr_bht_idx] = bht_q[w_wr_bht_idx] - 1'b1;
      end
      if (wr_taken) begin
        btb_valid_d[w_wr_btb_idx]  = 1'b1;
        btb_tag_d[w_wr_btb_idx]    = wr_pc[c_BTB_IDX_W+2 +: TAG_BITS];
        btb_target_d[w_wr_btb_idx] = wr_target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= c_CTR_INIT;
      end
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
      btb_valid_q <= '0;
      ghr_q       <= '0;
    end else begin
      bht_q        <= bht_d;
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      ghr_q        <= ghr_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, before state clears.
  always_comb begin
    pred_taken     = '0;
    pred_target    = '0;
    pred_is_branch = '0;
    pred_any_taken = 1'b0;
    pred_lane      = '0;
    pred_ghr       = '0;
    if (reset) begin
      pred_taken     = w_taken;
      pred_target    = w_target;
      pred_is_branch = w_hit;
      pred_any_taken = w_found;
      pred_lane      = w_lane;
      pred_ghr       = ghr_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gshare_predictor: directed scoreboard bench for gshare_predictor.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gshare_predictor;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              rd_en = 1'b0;
  logic [31:0]       rd_pc = 32'h0;
  logic [3:0]        pred_taken;
  logic [3:0][31:0]  pred_target;
  logic [3:0]        pred_is_branch;
  logic              pred_any_taken;
  logic [1:0]        pred_lane;
  logic [7:0]        pred_ghr;
  logic              wr_en = 1'b0;
  logic [31:0]       wr_pc = 32'h0;
  logic              wr_taken = 1'b0;
  logic [31:0]       wr_target = 32'h0;
  logic [7:0]        wr_ghr = 8'h0;
  logic              wr_mispredict = 1'b0;

  gshare_predictor #(
    .FETCH_WIDTH(4), .GHR_BITS(8), .BHT_ENTRIES(256),
    .CTR_BITS(2), .BTB_ENTRIES(32), .TAG_BITS(8)
  ) dut (
    .clock(clock), .reset(reset), .rd_en(rd_en), .rd_pc(rd_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_is_branch(pred_is_branch), .pred_any_taken(pred_any_taken),
    .pred_lane(pred_lane), .pred_ghr(pred_ghr),
    .wr_en(wr_en), .wr_pc(wr_pc), .wr_taken(wr_taken), .wr_target(wr_target),
    .wr_ghr(wr_ghr), .wr_mispredict(wr_mispredict)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]       br;
    logic [3:0]       tk;
    logic             any;
    logic [1:0]       lane;
    logic [7:0]       ghr;
    logic [3:0][31:0] tgt;
  } exp_t;

  exp_t  exp_q [$];
  string name_q[$];
  logic  chk_valid = 1'b0;
  logic  end_chk   = 1'b0;
  int    n_checks  = 0;
  int    n_pass    = 0;
  exp_t  mon_e;
  string mon_nm;

  always @(negedge clock) begin
    if (chk_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: lookup presented with no expected entry");
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        if (pred_is_branch === mon_e.br && pred_taken === mon_e.tk &&
            pred_any_taken === mon_e.any && pred_lane === mon_e.lane &&
            pred_ghr === mon_e.ghr && pred_target === mon_e.tgt) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got br=%b tk=%b any=%b lane=%0d ghr=%h tgt=%h, expected br=%b tk=%b any=%b lane=%0d ghr=%h tgt=%h",
                   mon_nm, pred_is_branch, pred_taken, pred_any_taken, pred_lane, pred_ghr, pred_target,
                   mon_e.br, mon_e.tk, mon_e.any, mon_e.lane, mon_e.ghr, mon_e.tgt);
        end
      end
    end else if (end_chk) begin
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL leftover: %0d expected entries never checked, required 0", exp_q.size());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    chk_valid     = 1'b0;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    wr_taken      = 1'b0;
    wr_mispredict = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic en);
    rd_pc = pc;
    rd_en = en;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic [7:0] g);
    wr_en     = 1'b1;
    wr_pc     = pc;
    wr_taken  = tk;
    wr_target = tgt;
    wr_ghr    = g;
  endtask

  function automatic logic [3:0][31:0] tgts(input logic [31:0] t3, input logic [31:0] t2,
                                            input logic [31:0] t1, input logic [31:0] t0);
    return {t3, t2, t1, t0};
  endfunction

  task automatic expect_pred(input string nm, input logic [3:0] br, input logic [3:0] tk,
                             input logic any, input logic [1:0] ln, input logic [7:0] g,
                             input logic [3:0][31:0] tg);
    exp_t e;
    e.br = br; e.tk = tk; e.any = any; e.lane = ln; e.ghr = g; e.tgt = tg;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_valid = 1'b1;
  endtask

  localparam logic [3:0][31:0] T_NONE = '0;

  initial begin
    tick();
    reset = 1'b0;
    lookup(32'h1000, 1'b1);
    expect_pred("reset_hold", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, T_NONE);
    tick();
    tick();
    reset = 1'b1;
    lookup(32'h1000, 1'b0);
    expect_pred("reset_lookup", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, T_NONE);

    // Training on pc 0x1008 (counter index 2, BTB index 2)
    tick(); train(32'h1008, 1'b1, 32'h2000, 8'h00); lookup(32'h1000, 1'b0);
    expect_pred("no_bypass", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, T_NONE);
    tick(); train(32'h1008, 1'b1, 32'h2000, 8'h00);
    expect_pred("train1", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h00, tgts(0, 32'h2000, 0, 0));
    tick(); train(32'h1008, 1'b1, 32'h2000, 8'h00);
    expect_pred("train2", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h00, tgts(0, 32'h2000, 0, 0));
    tick(); train(32'h1008, 1'b1, 32'h2000, 8'h00);
    tick(); train(32'h1008, 1'b1, 32'h2000, 8'h00);
    tick(); train(32'h1008, 1'b0, 32'h0, 8'h00);
    tick(); train(32'h1008, 1'b0, 32'h0, 8'h00);
    expect_pred("sat_hi", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h00, tgts(0, 32'h2000, 0, 0));
    tick(); train(32'h1008, 1'b0, 32'h0, 8'h00);
    expect_pred("dec_to_1", 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00, tgts(0, 32'h2000, 0, 0));
    tick(); train(32'h1008, 1'b0, 32'h0, 8'h00);
    tick(); train(32'h1008, 1'b0, 32'h0, 8'h00);
    tick(); train(32'h1008, 1'b1, 32'h2000, 8'h00);
    expect_pred("sat_lo", 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00, tgts(0, 32'h2000, 0, 0));
    tick(); train(32'h1008, 1'b1, 32'h2000, 8'h00);
    expect_pred("sat_lo_inc", 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00, tgts(0, 32'h2000, 0, 0));
    tick(); train(32'h1004, 1'b1, 32'h3000, 8'h00);
    expect_pred("ctr_up", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h00, tgts(0, 32'h2000, 0, 0));
    tick(); train(32'h100C, 1'b1, 32'h4000, 8'h00);

    // First-taken masking and speculative history
    tick(); lookup(32'h1000, 1'b1);
    expect_pred("first_taken_mask", 4'b1110, 4'b0010, 1'b1, 2'd1, 8'h00,
                tgts(32'h4000, 32'h2000, 32'h3000, 0));
    tick(); lookup(32'h1000, 1'b1);
    expect_pred("ghr_shift", 4'b1110, 4'b0100, 1'b1, 2'd2, 8'h01,
                tgts(32'h4000, 32'h2000, 32'h3000, 0));
    tick(); lookup(32'h1000, 1'b1);
    expect_pred("two_bit_shift", 4'b1110, 4'b0000, 1'b0, 2'd0, 8'h05,
                tgts(32'h4000, 32'h2000, 32'h3000, 0));
    tick(); lookup(32'h1000, 1'b0); train(32'h8000, 1'b0, 32'h0, 8'h00); wr_mispredict = 1'b1;
    expect_pred("all_nt_shift", 4'b1110, 4'b0000, 1'b0, 2'd0, 8'h28,
                tgts(32'h4000, 32'h2000, 32'h3000, 0));

    // Recovery beats the same-cycle rd_en shift
    tick(); lookup(32'h1000, 1'b1); train(32'h8000, 1'b0, 32'h0, 8'h5A); wr_mispredict = 1'b1;
    expect_pred("recover_to_zero", 4'b1110, 4'b0010, 1'b1, 2'd1, 8'h00,
                tgts(32'h4000, 32'h2000, 32'h3000, 0));
    tick(); lookup(32'h1000, 1'b0);
    expect_pred("recovery_priority", 4'b1110, 4'b0000, 1'b0, 2'd0, 8'hB4,
                tgts(32'h4000, 32'h2000, 32'h3000, 0));

    // Reset in the middle of traffic
    tick(); reset = 1'b0; lookup(32'h1000, 1'b1);
    train(32'h1010, 1'b1, 32'h5000, 8'h33); wr_mispredict = 1'b1;
    expect_pred("reset_mid", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, T_NONE);
    tick(); reset = 1'b1; lookup(32'h1000, 1'b0);
    expect_pred("post_reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, T_NONE);
    tick(); lookup(32'h1010, 1'b0); train(32'h1008, 1'b1, 32'h2000, 8'h00);
    expect_pred("post_reset_1010", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, T_NONE);
    tick(); lookup(32'h1000, 1'b0); train(32'h1008, 1'b0, 32'h0, 8'h00);
    expect_pred("ctr_reset_t", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h00, tgts(0, 32'h2000, 0, 0));
    tick(); lookup(32'h1000, 1'b0); train(32'h0000_0004, 1'b1, 32'h6000, 8'h00);
    expect_pred("ctr_reset_nt", 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00, tgts(0, 32'h2000, 0, 0));

    // Lane PCs wrap past 2**32; misaligned low bits ignored
    tick(); lookup(32'hFFFF_FFFE, 1'b0);
    expect_pred("pc_wrap", 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h00, tgts(0, 32'h6000, 0, 0));

    tick();
    tick();
    end_chk = 1'b1;
    @(negedge clock);
    #1;
    end_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
